// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: FSM state encoding,
// access-type codes, wait-counter sizing and a legal-type helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Largest supported RAM read latency; the wait counter is sized for it.
  localparam int LSU_RD_LAT_MAX = 7;
  localparam int LSU_CNT_W      = 3;

  function automatic logic is_legal_type(input logic [2:0] t);
    return (t == LS_B) || (t == LS_H) || (t == LS_W) || (t == LS_BU) || (t == LS_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the three ports of the memory stage: request from execute,
// response to writeback, and the data RAM port.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the sender keeps valid and its payload steady until then, and
// the stage's response payload is stable while resp_valid && !resp_ready.
interface lsu_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_is_load;
  logic        resp_fault;
  logic [31:0] resp_addr;

  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_rw_type;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // The memory stage itself.
  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_is_load,
    output resp_fault, resp_addr,
    output mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_wdata
  );

  // The surroundings: execute, writeback and the RAM.
  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, req_rd,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_is_load,
    input  resp_fault, resp_addr,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_wdata
  );
endinterface

// File: rtl/lsu_align_chk.sv
// Combinational access checker: flags misaligned halves/words, illegal
// type codes and sign-extending store types.
// Optional macro LSU_RANGE_CHECK_EN adds an out-of-range word index fault.
module lsu_align_chk
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic [2:0]  acc_type,
  input  logic [31:0] addr,
  input  logic        we,
  output logic        fault
);

  logic misaligned;
  logic range_bad;

  // Alignment requirement depends only on the access width.
  always_comb begin
    misaligned = 1'b0;
    case (acc_type)
      LS_H, LS_HU: misaligned = addr[0];
      LS_W:        misaligned = (addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  // Out-of-range words would alias in the RAM's narrow word index.
  assign range_bad = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_hi;
  assign unused_hi = ^addr[31:2];
  assign range_bad = 1'b0;
`endif

  assign fault = !is_legal_type(acc_type) || (we && acc_type[2]) || misaligned || range_bad;

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: accepts one request, performs exactly one RAM
// access (or none on a fault), then holds the result for writeback.
// RD_LAT (0..7) is the RAM read latency in extra cycles.
// Optional macro LSU_RANGE_CHECK_EN enables the DEPTH_WORDS range fault.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int RD_LAT      = 0,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_stage_if.slave    bus,
  output lsu_state_t        dbg_state
);

  lsu_state_t            state;
  lsu_state_t            state_nxt;
  logic                  fault;
  logic                  lat_is_load;
  logic [2:0]            lat_type;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [4:0]            lat_rd;
  logic                  lat_fault;
  logic [31:0]           lat_data;
  logic [LSU_CNT_W-1:0]  wait_cnt;

  lsu_align_chk #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_align_chk (
    .acc_type (bus.req_type),
    .addr     (bus.req_addr),
    .we       (bus.req_we),
    .fault    (fault)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: faults skip the RAM, loads with latency pass through WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.req_valid) state_nxt = fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = (!lat_is_load || (RD_LAT == 0)) ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (wait_cnt == LSU_CNT_W'(1)) state_nxt = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and load-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_is_load <= 1'b0;
      lat_type    <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_rd      <= '0;
      lat_fault   <= 1'b0;
      lat_data    <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_is_load <= !bus.req_we;
            lat_type    <= bus.req_type;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            lat_rd      <= bus.req_rd;
            lat_fault   <= fault;
            lat_data    <= '0;
          end
        end
        ST_ACCESS: begin
          if (lat_is_load) begin
            if (RD_LAT == 0) lat_data <= bus.mem_rdata;
            else             wait_cnt <= LSU_CNT_W'(RD_LAT);
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - LSU_CNT_W'(1);
          if (wait_cnt == LSU_CNT_W'(1)) lat_data <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so the RAM enables vanish the moment rst rises.
  always_comb begin
    bus.req_ready    = (state == ST_IDLE);
    bus.resp_valid   = (state == ST_RESP);
    bus.resp_data    = lat_data;
    bus.resp_rd      = lat_rd;
    bus.resp_is_load = lat_is_load;
    bus.resp_fault   = lat_fault;
    bus.resp_addr    = lat_addr;
    bus.mem_wr_en    = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_rw_type  = '0;
    bus.mem_wdata    = '0;
    if ((state == ST_ACCESS) || (state == ST_WAIT)) begin
      bus.mem_addr    = lat_addr;
      bus.mem_rw_type = lat_type;
      bus.mem_wdata   = lat_wdata;
      bus.mem_rd_en   = lat_is_load;
      bus.mem_wr_en   = (state == ST_ACCESS) && !lat_is_load;
    end
    dbg_state = state;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: one instance with RD_LAT=0, one with RD_LAT=2,
// each attached to a small RAM model; directed table, corner sequences and
// random traffic checked against a byte-array reference model.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and muxed view ----------------
  lsu_mem_stage_if b0();
  lsu_mem_stage_if b2();
  lsu_state_t st0, st2;

  lsu_mem_stage #(.RD_LAT(0), .DEPTH_WORDS(256)) dut0 (.clk(clk), .rst(rst), .bus(b0), .dbg_state(st0));
  lsu_mem_stage #(.RD_LAT(2), .DEPTH_WORDS(256)) dut2 (.clk(clk), .rst(rst), .bus(b2), .dbg_state(st2));

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_type = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;

  assign b0.req_valid = req_valid & ~sel;
  assign b2.req_valid = req_valid & sel;
  assign b0.resp_ready = resp_ready & ~sel;
  assign b2.resp_ready = resp_ready & sel;
  assign b0.req_we = req_we;       assign b2.req_we = req_we;
  assign b0.req_type = req_type;   assign b2.req_type = req_type;
  assign b0.req_addr = req_addr;   assign b2.req_addr = req_addr;
  assign b0.req_wdata = req_wdata; assign b2.req_wdata = req_wdata;
  assign b0.req_rd = req_rd;       assign b2.req_rd = req_rd;

  logic        m_req_ready, m_resp_valid, m_resp_is_load, m_resp_fault, m_mem_wr_en, m_mem_rd_en;
  logic [31:0] m_resp_data, m_resp_addr, m_mem_addr, m_mem_wdata;
  logic [4:0]  m_resp_rd;
  logic [2:0]  m_mem_rw_type;
  lsu_state_t  m_state;
  assign m_req_ready    = sel ? b2.req_ready    : b0.req_ready;
  assign m_resp_valid   = sel ? b2.resp_valid   : b0.resp_valid;
  assign m_resp_data    = sel ? b2.resp_data    : b0.resp_data;
  assign m_resp_rd      = sel ? b2.resp_rd      : b0.resp_rd;
  assign m_resp_is_load = sel ? b2.resp_is_load : b0.resp_is_load;
  assign m_resp_fault   = sel ? b2.resp_fault   : b0.resp_fault;
  assign m_resp_addr    = sel ? b2.resp_addr    : b0.resp_addr;
  assign m_mem_wr_en    = sel ? b2.mem_wr_en    : b0.mem_wr_en;
  assign m_mem_rd_en    = sel ? b2.mem_rd_en    : b0.mem_rd_en;
  assign m_mem_addr     = sel ? b2.mem_addr     : b0.mem_addr;
  assign m_mem_rw_type  = sel ? b2.mem_rw_type  : b0.mem_rw_type;
  assign m_mem_wdata    = sel ? b2.mem_wdata    : b0.mem_wdata;
  assign m_state        = sel ? st2 : st0;

  // ---------------- RAM models (environment, word organised) ----------------
  logic [31:0] ram0 [256];
  logic [31:0] ram2 [256];
  logic [31:0] pipe2 [2];

  function automatic logic [31:0] ram_ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] t);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (t)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] off, input logic [2:0] t);
    logic [31:0] r;
    r = old;
    case (t[1:0])
      2'b00:   r[8*off +: 8]  = wd[7:0];
      2'b01:   r[8*off +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign b0.mem_rdata = ram_ext(ram0[b0.mem_addr[9:2]], b0.mem_addr[1:0], b0.mem_rw_type);
  assign b2.mem_rdata = pipe2[1];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        ram0[i] <= 32'h0;
        ram2[i] <= 32'h0;
      end
      pipe2[0] <= 32'h0;
      pipe2[1] <= 32'h0;
    end else begin
      if (b0.mem_wr_en)
        ram0[b0.mem_addr[9:2]] <= ram_merge(ram0[b0.mem_addr[9:2]], b0.mem_wdata, b0.mem_addr[1:0], b0.mem_rw_type);
      if (b2.mem_wr_en)
        ram2[b2.mem_addr[9:2]] <= ram_merge(ram2[b2.mem_addr[9:2]], b2.mem_wdata, b2.mem_addr[1:0], b2.mem_rw_type);
      pipe2[0] <= ram_ext(ram2[b2.mem_addr[9:2]], b2.mem_addr[1:0], b2.mem_rw_type);
      pipe2[1] <= pipe2[0];
    end
  end

  // ---------------- reference model (byte array) ----------------
  logic [7:0] ref_mem [2][1024];

  task automatic model(input int s, input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, output logic f, output logic [31:0] d);
    int ix, nb;
    logic [31:0] v;
    ix = int'(a[9:0]);
    d = 32'h0;
    nb = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    f = !(t == 3'b000 || t == 3'b001 || t == 3'b010 || t == 3'b100 || t == 3'b101);
    if (we && t[2]) f = 1'b1;
    if ((a % nb) != 0) f = 1'b1;
    if (f) return;
    if (we) begin
      for (int k = 0; k < nb; k++) ref_mem[s][(ix + k) % 1024] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[s][(ix + k) % 1024]) << (8 * k));
      if (!t[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!t[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      d = v;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [70:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver: one full transaction on the selected DUT ----------------
  task automatic do_txn(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int hold, input logic exp_f, input logic [31:0] exp_d,
                        input string tag);
    int guard, lat, n_rd, n_wr, exp_lat;
    logic [70:0] exp, got;
    exp_q.push_back({exp_f, ~we, rd, a, exp_d});
    req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1; resp_ready = 1'b0;
    guard = 0;
    while (!m_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_f) cmp({tag, "_mem_bus"}, {m_mem_addr, m_mem_rw_type}, {a, t});
    if (!exp_f && we) cmp({tag, "_mem_wdata"}, m_mem_wdata, wd);
    lat = 1; n_rd = 0; n_wr = 0;
    while (!m_resp_valid && lat < 20) begin
      n_rd += int'(m_mem_rd_en);
      n_wr += int'(m_mem_wr_en);
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = exp_f ? 1 : (we ? 2 : 2 + (sel ? 2 : 0));
    cmp({tag, "_latency"}, lat, exp_lat);
    cmp({tag, "_rd_en_cycles"}, n_rd, (!exp_f && !we) ? 1 + (sel ? 2 : 0) : 0);
    cmp({tag, "_wr_en_cycles"}, n_wr, (!exp_f && we) ? 1 : 0);
    exp = exp_q.pop_front();
    got = {m_resp_fault, m_resp_is_load, m_resp_rd, m_resp_addr, m_resp_data};
    cmp({tag, "_resp"}, got, exp);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      cmp({tag, "_resp_hold"},
          {m_resp_valid, m_req_ready, m_mem_wr_en, m_mem_rd_en, m_mem_addr,
           m_resp_fault, m_resp_is_load, m_resp_rd, m_resp_addr, m_resp_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, exp});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    cmp({tag, "_release"}, {m_resp_valid, m_req_ready, m_state}, {1'b0, 1'b1, ST_IDLE});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          hold;
    logic        exp_f;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic        f;
    logic [31:0] d;
    logic        we;
    logic [2:0]  t;
    logic [31:0] a, wd;

    vecs[0]  = '{1'b1, LS_W,   32'h10, 32'hDEADBEEF, 5'd1,  0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, LS_W,   32'h10, 32'h0,        5'd2,  0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, LS_B,   32'h13, 32'h00000080, 5'd3,  0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, LS_B,   32'h13, 32'h0,        5'd4,  0, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, LS_BU,  32'h13, 32'h0,        5'd5,  0, 1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, LS_H,   32'h11, 32'h0,        5'd6,  0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, LS_W,   32'h10, 32'h0,        5'd7,  5, 1'b0, 32'h80ADBEEF};
    vecs[7]  = '{1'b0, LS_H,   32'h12, 32'h0,        5'd8,  0, 1'b0, 32'hFFFF80AD};
    vecs[8]  = '{1'b0, LS_HU,  32'h12, 32'h0,        5'd9,  1, 1'b0, 32'h000080AD};
    vecs[9]  = '{1'b1, LS_BU,  32'h20, 32'h55,       5'd10, 0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'b011, 32'h20, 32'h0,        5'd11, 0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, LS_W,   32'h16, 32'h12345678, 5'd12, 0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, LS_H,   32'h14, 32'hABCD7001, 5'd13, 0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, LS_H,   32'h14, 32'h0,        5'd14, 2, 1'b0, 32'h00007001};

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = 8'h0;

    // reset phase
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      cmp("reset_handshake", {m_req_ready, m_resp_valid, m_state}, {1'b1, 1'b0, ST_IDLE});
      cmp("reset_resp", {m_resp_data, m_resp_rd, m_resp_is_load, m_resp_fault, m_resp_addr}, '0);
      cmp("reset_mem", {m_mem_wr_en, m_mem_rd_en, m_mem_addr, m_mem_rw_type, m_mem_wdata}, '0);
    end
    rst = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // table on the zero-latency instance
    for (int i = 0; i < 14; i++) begin
      model(0, vecs[i].we, vecs[i].t, vecs[i].a, vecs[i].wd, f, d);
      do_txn(vecs[i].we, vecs[i].t, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].hold,
             vecs[i].exp_f, vecs[i].exp_d, $sformatf("vec%0d", i));
    end

    // reset in the middle of a store's RAM cycle
    model(0, 1'b1, LS_W, 32'h30, 32'hA5A5A5A5, f, d);
    do_txn(1'b1, LS_W, 32'h30, 32'hA5A5A5A5, 5'd0, 0, 1'b0, 32'h0, "abort_pre");
    req_we = 1'b1; req_type = LS_W; req_addr = 32'h30; req_wdata = 32'h12345678; req_rd = 5'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cmp("abort_wr_active", m_mem_wr_en, 1'b1);
    rst = 1'b1;
    #1;
    cmp("abort_wr_drop", m_mem_wr_en, 1'b0);
    cmp("abort_idle", {m_state, m_req_ready, m_resp_valid}, {ST_IDLE, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("abort_ram_word", ram0[12], 32'hA5A5A5A5);
    @(posedge clk); #1;
    model(0, 1'b0, LS_W, 32'h30, 32'h0, f, d);
    do_txn(1'b0, LS_W, 32'h30, 32'h0, 5'd3, 0, 1'b0, 32'hA5A5A5A5, "abort_post");

    // two-cycle read latency instance
    sel = 1'b1;
    #1;
    model(1, 1'b1, LS_W, 32'h20, 32'hCAFEF00D, f, d);
    do_txn(1'b1, LS_W, 32'h20, 32'hCAFEF00D, 5'd1, 0, 1'b0, 32'h0, "lat2_sw");
    model(1, 1'b0, LS_W, 32'h20, 32'h0, f, d);
    do_txn(1'b0, LS_W, 32'h20, 32'h0, 5'd2, 0, 1'b0, 32'hCAFEF00D, "lat2_lw");
    model(1, 1'b0, LS_HU, 32'h13, 32'h0, f, d);
    do_txn(1'b0, LS_HU, 32'h13, 32'h0, 5'd3, 0, 1'b1, 32'h0, "lat2_fault");

    // random traffic on both instances against the reference model
    for (int n = 0; n < 160; n++) begin
      sel = n[0] ^ $urandom_range(0, 1) ? 1'b1 : 1'b0;
      #1;
      we = $urandom_range(0, 1) ? 1'b1 : 1'b0;
      t  = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      wd = $urandom;
      model(int'(sel), we, t, a, wd, f, d);
      do_txn(we, t, a, wd, 5'($urandom_range(0, 31)), $urandom_range(0, 3), f, d, "rnd");
    end

    cmp("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access pipeline stage that sits directly upstream of the byte/half/word data RAM.
- Accepts load/store requests from the execute stage with a valid/ready handshake and checks alignment and access type.
- Drives the RAM port for exactly one access per request, then captures the load data (already extended by the RAM) or the store completion.
- Presents the result to writeback through a valid/ready output register.

Parameters:
- RD_LAT, 0, extra cycles between driving the RAM read and sampling mem_rdata (0 = combinational RAM read); range 0..7.
- DEPTH_WORDS, 256, number of 32-bit RAM words; used only by the optional range check.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  stage can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register, passed through.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_rd  out  5  latched req_rd.
- resp_is_load  out  1  latched ~req_we.
- resp_fault  out  1  misaligned or illegal access.
- resp_addr  out  32  latched req_addr.
- mem_wr_en  out  1  RAM write enable.
- mem_rd_en  out  1  RAM read enable.
- mem_addr  out  32  RAM address.
- mem_rw_type  out  3  RAM access type.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, already extended.

Behaviour:
- Reset: state IDLE.
  - req_ready=1; resp_valid=0; resp_data=0; resp_rd=0; resp_is_load=0; resp_fault=0; resp_addr=0.
  - mem_wr_en=0; mem_rd_en=0; mem_addr=0; mem_rw_type=0; mem_wdata=0.
  - Reset mid-access aborts immediately. mem_wr_en is decoded from state, so a pending write is never issued after rst rises.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request.
  - If faulty, go to RESP with resp_fault=1; no RAM enable is ever asserted.
  - Otherwise go to ACCESS.
- Fault conditions:
  - Half (001/101) with addr[0]=1.
  - Word (010) with addr[1:0]!=0.
  - Illegal type: 011, 110, 111.
  - Store with type[2]=1.
- ACCESS:
  - Drive mem_addr, mem_rw_type and mem_wdata from the latched registers.
  - For a store, mem_wr_en=1 for exactly this one cycle; for a load, mem_rd_en=1.
  - Store: go to RESP.
  - Load with RD_LAT=0: capture mem_rdata into resp_data at the end of this cycle and go to RESP.
  - Load with RD_LAT>0: go to WAIT with wait counter = RD_LAT.
- WAIT:
  - Hold the mem_* outputs and mem_rd_en=1.
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata and go to RESP.
- RESP:
  - resp_valid=1; all resp_* fields are stable while resp_valid=1 && !resp_ready.
  - On resp_ready, go to IDLE.
  - req_ready=0 in every non-IDLE state, so there is no overlap.
- Latency: request accepted at edge N gives resp_valid at edge N+2+RD_LAT; a fault gives resp_valid at N+1.
- Throughput: at most one request per 3+RD_LAT cycles.
- The mem_* outputs return to 0 whenever state is IDLE or RESP.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- When defined: an address with addr[31:2] >= DEPTH_WORDS is also a fault. No RAM access is made and resp_fault=1. This prevents aliasing in the RAM's 8-bit word index.
- When undefined: there is no range check and high address bits pass through unchanged.

Decomposition:
- Package lsu_pkg: state encoding, access-type constants (LS_B, LS_H, LS_W, LS_BU, LS_HU), and the RD_LAT maximum.
- Sub-module lsu_align_chk: purely combinational. Inputs are type, addr and we; the output is the fault flag, including the optional range check.

Test Plan:
- Store sw addr=0x10 data=0xDEADBEEF, then lw addr=0x10 → mem_wr_en high for exactly 1 cycle; resp_data=0xDEADBEEF at N+2, resp_fault=0.
- sb 0x80 to addr 0x13, then lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080.
- lh addr=0x11 → resp_fault=1 at N+1; mem_rd_en and mem_wr_en never asserted; resp_data=0.
- resp_ready held 0 for 5 cycles after a load → resp_valid and resp_data stable, req_ready=0; completes on resp_ready=1.
- RD_LAT=2, lw addr=0x20 → mem_rd_en high 3 cycles; resp_valid at N+4.
- rst pulsed during ACCESS of sw addr=0x30 → mem_wr_en drops immediately; RAM word 0x30 unchanged; state IDLE, req_ready=1.
